music_seq: RTL and testbench
============================

# music_seq

Parametrised multi-channel square-wave sequencer, the successor to the fixed single-voice tune player. It holds a writable pattern memory of `DEPTH` steps × `CHANNELS` voices. It plays the pattern at a tempo-derived step rate, with per-step note, sustain (phase-continuous), rest and end/loop control. It sits between a control/loader interface and the board speaker pins.

## Interface
- `CLK_FREQ`, 100_000_000: clock frequency in Hz.
- `TEMPO`, 120: beats per minute.
- `STEPS_PER_BEAT`, 4: pattern steps per beat.
- `DEPTH`, 16: steps per pattern; power of 2, ≥2. `AW = $clog2(DEPTH)`.
- `CHANNELS`, 2: independent voices, ≥1. `CW = max(1, $clog2(CHANNELS))`.

Ports:
- `clk` in 1: single clock. All logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begin playback (pulse).
- `stop` in 1: abort playback (pulse).
- `loop_en` in 1: wrap to step 0 at pattern end instead of finishing.
- `wr_en` in 1: pattern memory write strobe.
- `wr_ch` in CW: channel to write.
- `wr_addr` in AW: step to write.
- `wr_data` in 6: entry `{op[1:0], pitch[3:0]}`.
- `speaker` out CHANNELS: square-wave output per channel.
- `busy` out 1: high while playing.
- `step_idx` out AW: step currently sounding.
- `step_tick` out 1: 1-cycle pulse when a step is applied.
- `done` out 1: 1-cycle pulse on natural completion.

## Operation
- `STEP_PERIOD = (60*CLK_FREQ)/(TEMPO*STEPS_PER_BEAT)` cycles, using integer division.
- Pitch ROM index 0..15 maps to 261, 277, 293, 311, 329, 349, 369, 392, 415, 440, 466, 493, 523, 554, 587, 622 Hz.
  - Half-period is `CLK_FREQ/(2*f)`, integer division, 32-bit.
- Ops are applied per channel at each step:
  - **00 SUSTAIN**: tone state unchanged; the tone counter keeps running across the boundary with no phase reset. If the channel is not sounding, it stays silent.
  - **01 NOTE**: load half-period from the ROM, clear the tone counter, `speaker[c]`←0, sounding←1.
  - **10 REST**: sounding←0, `speaker[c]`←0.
  - **11 END**: on channel 0 it is the pattern terminator; on other channels it behaves as REST.
- While sounding, the tone counter increments every cycle. At count == half-period−1 it toggles `speaker[c]` and clears the counter.
- State machine:
  - **IDLE**:
    - `start`=1 and `stop`=0: go to PLAY; all channels not sounding; apply step 0.
    - Otherwise stay in IDLE.
  - **PLAY**: the step timer counts 0..STEP_PERIOD−1. At STEP_PERIOD−1 the next step is applied:
    - If `step_idx` < DEPTH−1: apply `step_idx`+1.
    - If `step_idx` == DEPTH−1: if `loop_en`, apply step 0; else go to IDLE and pulse `done`.
    - `stop`=1 has priority over everything: go to IDLE, clear all `speaker` bits, no `done`.
    - `start` is ignored in PLAY.
- END handling:
  - END on channel 0 at step k>0 replaces that step. In the same cycle it is evaluated as a pattern-end boundary: if `loop_en`, step 0 is applied the next cycle; else go to IDLE and pulse `done`.
  - Step k therefore occupies exactly one cycle, with `step_tick` asserted.
  - END at step 0 always goes to IDLE with `done`, regardless of `loop_en`.
- Pattern memory:
  - Writable at any time.
  - A write to the entry being applied in the same cycle takes effect next time; the old value is used now.
  - Reset clears every entry to REST (6'b10_0000).

## Timing
- Reset values: `speaker`=0, `busy`=0, `step_idx`=0, `step_tick`=0, `done`=0, state IDLE, timers 0, memory all REST.
- `start` sampled high at edge T:
  - At T+1: `busy`=1, `step_idx`=0, `step_tick`=1, and step-0 ops are in effect.
  - The first toggle of a NOTE occurs at T+1+half-period.
- Step boundaries occur every STEP_PERIOD cycles. `step_tick` and the `step_idx` update land on the same cycle as the new ops.
- Natural finish:
  - `busy` falls and `done` pulses on the cycle after the last step's final cycle.
  - `speaker` is cleared on that same cycle.
- `stop` at edge T: from T+1, `busy`=0 and `speaker`=0.
- `rst` at edge T: all outputs at reset values from T+1, including mid-play and mid-write.
- `start` and `stop` together in IDLE: stay in IDLE.

## Test plan
Bench parameters: CLK_FREQ=8000, TEMPO=60, STEPS_PER_BEAT=4, DEPTH=8, CHANNELS=2, giving STEP_PERIOD=2000, half(440 Hz)=9, half(261 Hz)=15, half(523 Hz)=7.
- **Idle after reset**: reset, no start, run 20000 cycles -> all outputs stay 0.
- **Note, sustain, finish**: ch0 = NOTE 9, SUSTAIN, then REST×6; start -> `speaker[0]` toggles every 9 cycles for 4000 cycles with no phase break at cycle 2000; silent after that; `done` pulses 16000 cycles after step 0 is applied; `busy` is then 0.
- **Loop with END**: `loop_en`=1, ch0 step 3 = END -> `step_idx` sequence 0,1,2,3,0,1…; `step_tick` spacing 2000, 2000, 2000, 1; `done` never pulses.
- **Abort**: `stop` at cycle 3000 of play -> next cycle `busy`=0 and `speaker`=0; `done` stays 0; a later `start` replays from step 0.
- **Two voices**: ch0 NOTE 0, ch1 NOTE 12 -> `speaker[0]` period 30 cycles and `speaker[1]` period 14 cycles, concurrent and independent.
- **Reset mid-play**: `rst` at cycle 2500 of play -> next cycle all outputs 0; a subsequent `start` plays silence for 8 steps, then `done`.

Source files
------------

// File: rtl/music_seq.sv
// Multi-channel square-wave pattern sequencer: a writable DEPTH x CHANNELS
// pattern memory played at a tempo-derived step rate.
module music_seq #(
  parameter int unsigned CLK_FREQ       = 100_000_000,
  parameter int unsigned TEMPO          = 120,
  parameter int unsigned STEPS_PER_BEAT = 4,
  parameter int unsigned DEPTH          = 16,
  parameter int unsigned CHANNELS       = 2,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                stop,
  input  logic                loop_en,
  input  logic                wr_en,
  input  logic [CW-1:0]       wr_ch,
  input  logic [AW-1:0]       wr_addr,
  input  logic [5:0]          wr_data,
  output logic [CHANNELS-1:0] speaker,
  output logic                busy,
  output logic [AW-1:0]       step_idx,
  output logic                step_tick,
  output logic                done
);

  typedef enum logic [1:0] {
    OP_SUSTAIN = 2'b00,
    OP_NOTE    = 2'b01,
    OP_REST    = 2'b10,
    OP_END     = 2'b11
  } op_e;

  typedef enum logic {
    S_IDLE,
    S_PLAY
  } state_e;

  localparam logic [5:0]  ENTRY_REST  = 6'b10_0000;
  // 60*CLK_FREQ overflows 32 bits at realistic clock rates, so widen first.
  localparam logic [31:0] STEP_PERIOD =
    32'((64'd60 * 64'(CLK_FREQ)) / (64'(TEMPO) * 64'(STEPS_PER_BEAT)));
  localparam logic [AW-1:0] LAST_STEP = AW'(DEPTH - 1);

  function automatic logic [31:0] half_period(input logic [3:0] pitch);
    int unsigned f;
    case (pitch)
      4'd0:    f = 261;
      4'd1:    f = 277;
      4'd2:    f = 293;
      4'd3:    f = 311;
      4'd4:    f = 329;
      4'd5:    f = 349;
      4'd6:    f = 369;
      4'd7:    f = 392;
      4'd8:    f = 415;
      4'd9:    f = 440;
      4'd10:   f = 466;
      4'd11:   f = 493;
      4'd12:   f = 523;
      4'd13:   f = 554;
      4'd14:   f = 587;
      default: f = 622;
    endcase
    return 32'(CLK_FREQ / (2 * f));
  endfunction

  logic [5:0]          mem_q [CHANNELS][DEPTH];

  state_e              state_q;
  logic                busy_q;
  logic [AW-1:0]       step_idx_q;
  logic                step_tick_q;
  logic                done_q;
  logic                end_pend_q;
  logic [31:0]         timer_q;
  logic [CHANNELS-1:0] speaker_q;
  logic [CHANNELS-1:0] sounding_q;
  logic [31:0]         half_q [CHANNELS];
  logic [31:0]         cnt_q  [CHANNELS];

  logic                apply_c;
  logic                finish_c;
  logic                abort_c;
  logic [AW-1:0]       apply_idx_c;
  logic [5:0]          entry_c [CHANNELS];
  logic                ch0_end_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        for (int unsigned s = 0; s < DEPTH; s++) begin
          mem_q[CW'(c)][AW'(s)] <= ENTRY_REST;
        end
      end
    end else if (wr_en && (32'(wr_ch) < CHANNELS)) begin
      mem_q[wr_ch][wr_addr] <= wr_data;
    end
  end

  // A pending END on channel 0 turns the very next cycle into a pattern-end
  // boundary; END at step 0 always finishes so a lone terminator cannot spin.
  always_comb begin
    apply_c     = 1'b0;
    finish_c    = 1'b0;
    abort_c     = 1'b0;
    apply_idx_c = '0;
    case (state_q)
      S_IDLE: apply_c = start && !stop;
      S_PLAY: begin
        if (stop) begin
          abort_c = 1'b1;
        end else if (end_pend_q) begin
          if (loop_en && (step_idx_q != '0)) apply_c = 1'b1;
          else                               finish_c = 1'b1;
        end else if (timer_q == STEP_PERIOD - 32'd1) begin
          if (step_idx_q == LAST_STEP) begin
            if (loop_en) apply_c = 1'b1;
            else         finish_c = 1'b1;
          end else begin
            apply_c     = 1'b1;
            apply_idx_c = step_idx_q + AW'(1);
          end
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      entry_c[CW'(c)] = mem_q[CW'(c)][apply_idx_c];
    end
    ch0_end_c = (entry_c[0][5:4] == OP_END);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      step_idx_q  <= '0;
      step_tick_q <= 1'b0;
      done_q      <= 1'b0;
      end_pend_q  <= 1'b0;
      timer_q     <= '0;
      speaker_q   <= '0;
      sounding_q  <= '0;
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        half_q[CW'(c)] <= '0;
        cnt_q[CW'(c)]  <= '0;
      end
    end else begin
      step_tick_q <= 1'b0;
      done_q      <= 1'b0;
      if (abort_c || finish_c) begin
        state_q    <= S_IDLE;
        busy_q     <= 1'b0;
        done_q     <= finish_c;
        end_pend_q <= 1'b0;
        timer_q    <= '0;
        speaker_q  <= '0;
        sounding_q <= '0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
          cnt_q[CW'(c)] <= '0;
        end
      end else begin
        if (apply_c) begin
          state_q     <= S_PLAY;
          busy_q      <= 1'b1;
          step_idx_q  <= apply_idx_c;
          step_tick_q <= 1'b1;
          timer_q     <= '0;
          end_pend_q  <= ch0_end_c;
        end else if (state_q == S_PLAY) begin
          timer_q <= timer_q + 32'd1;
        end
        // SUSTAIN leaves the tone running; starting from IDLE it stays silent.
        for (int unsigned c = 0; c < CHANNELS; c++) begin
          if (apply_c && ((state_q == S_IDLE) ||
                          (entry_c[CW'(c)][5:4] != OP_SUSTAIN))) begin
            cnt_q[CW'(c)]     <= '0;
            speaker_q[CW'(c)] <= 1'b0;
            if (entry_c[CW'(c)][5:4] == OP_NOTE) begin
              sounding_q[CW'(c)] <= 1'b1;
              half_q[CW'(c)]     <= half_period(entry_c[CW'(c)][3:0]);
            end else begin
              sounding_q[CW'(c)] <= 1'b0;
            end
          end else if (sounding_q[CW'(c)]) begin
            if (cnt_q[CW'(c)] == half_q[CW'(c)] - 32'd1) begin
              speaker_q[CW'(c)] <= ~speaker_q[CW'(c)];
              cnt_q[CW'(c)]     <= '0;
            end else begin
              cnt_q[CW'(c)] <= cnt_q[CW'(c)] + 32'd1;
            end
          end
        end
      end
    end
  end

  assign speaker   = speaker_q;
  assign busy      = busy_q;
  assign step_idx  = step_idx_q;
  assign step_tick = step_tick_q;
  assign done      = done_q;

endmodule

// File: tb/tb_music_seq.sv
// Directed bench for music_seq: STEP_PERIOD=2000, half-periods 9/15/7 for
// pitch indices 9/0/12.
module tb_music_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       loop_en = 1'b0;
  logic       wr_en = 1'b0;
  logic [0:0] wr_ch = '0;
  logic [2:0] wr_addr = '0;
  logic [5:0] wr_data = '0;
  logic [1:0] speaker;
  logic       busy;
  logic [2:0] step_idx;
  logic       step_tick;
  logic       done;

  int n_checks = 0;
  int n_fail   = 0;

  music_seq #(
    .CLK_FREQ      (8000),
    .TEMPO         (60),
    .STEPS_PER_BEAT(4),
    .DEPTH         (8),
    .CHANNELS      (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .stop     (stop),
    .loop_en  (loop_en),
    .wr_en    (wr_en),
    .wr_ch    (wr_ch),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .speaker  (speaker),
    .busy     (busy),
    .step_idx (step_idx),
    .step_tick(step_tick),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic wr(input logic [0:0] ch, input logic [2:0] addr, input logic [5:0] data);
    wr_en = 1'b1; wr_ch = ch; wr_addr = addr; wr_data = data;
    cyc();
    wr_en = 1'b0;
  endtask

  task automatic go();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic halt();
    stop = 1'b1;
    cyc();
    stop = 1'b0;
  endtask

  task automatic test_reset();
    int bad;
    bad = 0;
    do_reset();
    n_checks++; if (speaker !== 2'b00) begin n_fail++; $display("FAIL reset_speaker: got %b expected 00", speaker); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (step_idx !== 3'd0) begin n_fail++; $display("FAIL reset_step_idx: got %0d expected 0", step_idx); end
    n_checks++; if (step_tick !== 1'b0) begin n_fail++; $display("FAIL reset_step_tick: got %b expected 0", step_tick); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    for (int i = 0; i < 20000; i++) begin
      cyc();
      if ({speaker, busy, step_idx, step_tick, done} !== 8'd0) bad++;
    end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL idle_quiet: got %0d active cycles expected 0", bad); end
  endtask

  task automatic test_start_stop_idle();
    do_reset();
    start = 1'b1; stop = 1'b1;
    cyc();
    start = 1'b0; stop = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL start_stop_busy: got %b expected 0", busy); end
    n_checks++; if (step_tick !== 1'b0) begin n_fail++; $display("FAIL start_stop_tick: got %b expected 0", step_tick); end
  endtask

  task automatic test_note_sustain_finish();
    int bad_spk, bad_tick, bad_idx, bad_busy, bad_done, first_bad;
    logic exp_spk;
    logic [1:0] s8, s9, s2007;
    bad_spk = 0; bad_tick = 0; bad_idx = 0; bad_busy = 0; bad_done = 0; first_bad = -1;
    s8 = '0; s9 = '0; s2007 = '0;
    do_reset();
    loop_en = 1'b0;
    wr(1'b0, 3'd0, 6'b01_1001);
    wr(1'b0, 3'd1, 6'b00_0000);
    go();
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL first_busy: got %b expected 1", busy); end
    n_checks++; if (step_idx !== 3'd0) begin n_fail++; $display("FAIL first_idx: got %0d expected 0", step_idx); end
    n_checks++; if (step_tick !== 1'b1) begin n_fail++; $display("FAIL first_tick: got %b expected 1", step_tick); end
    n_checks++; if (speaker !== 2'b00) begin n_fail++; $display("FAIL first_speaker: got %b expected 00", speaker); end
    for (int i = 1; i <= 16001; i++) begin
      cyc();
      exp_spk = (i < 4000) ? 1'((i / 9) % 2) : 1'b0;
      if (i == 8) s8 = speaker;
      if (i == 9) s9 = speaker;
      if (i == 2007) s2007 = speaker;
      if (speaker !== {1'b0, exp_spk}) begin bad_spk++; if (first_bad < 0) first_bad = i; end
      if (i < 16000) begin
        if (step_tick !== ((i % 2000) == 0)) bad_tick++;
        if (step_idx !== 3'(i / 2000)) bad_idx++;
        if (busy !== 1'b1) bad_busy++;
        if (done !== 1'b0) bad_done++;
      end else if (i == 16000) begin
        if (step_tick !== 1'b0) bad_tick++;
        if (busy !== 1'b0) bad_busy++;
        if (done !== 1'b1) bad_done++;
      end else begin
        if (busy !== 1'b0) bad_busy++;
        if (done !== 1'b0) bad_done++;
      end
    end
    n_checks++; if (s8 !== 2'b00) begin n_fail++; $display("FAIL note_pre_toggle: got %b expected 00", s8); end
    n_checks++; if (s9 !== 2'b01) begin n_fail++; $display("FAIL note_first_toggle: got %b expected 01", s9); end
    n_checks++; if (s2007 !== 2'b01) begin n_fail++; $display("FAIL sustain_phase: got %b expected 01", s2007); end
    n_checks++; if (bad_spk !== 0) begin n_fail++; $display("FAIL note_waveform: got %0d bad cycles (first %0d) expected 0", bad_spk, first_bad); end
    n_checks++; if (bad_tick !== 0) begin n_fail++; $display("FAIL note_step_tick: got %0d bad cycles expected 0", bad_tick); end
    n_checks++; if (bad_idx !== 0) begin n_fail++; $display("FAIL note_step_idx: got %0d bad cycles expected 0", bad_idx); end
    n_checks++; if (bad_busy !== 0) begin n_fail++; $display("FAIL note_busy: got %0d bad cycles expected 0", bad_busy); end
    n_checks++; if (bad_done !== 0) begin n_fail++; $display("FAIL note_done: got %0d bad cycles expected 0", bad_done); end
  endtask

  task automatic test_loop_end();
    int bad_tick, bad_idx, n_ticks, n_done, bad_busy, p;
    logic [2:0] exp_idx;
    bad_tick = 0; bad_idx = 0; n_ticks = 0; n_done = 0; bad_busy = 0;
    do_reset();
    loop_en = 1'b1;
    wr(1'b0, 3'd3, 6'b11_0000);
    go();
    for (int i = 1; i <= 12002; i++) begin
      cyc();
      p = i % 6001;
      exp_idx = (p < 2000) ? 3'd0 : (p < 4000) ? 3'd1 : (p < 6000) ? 3'd2 : 3'd3;
      if (step_tick === 1'b1) n_ticks++;
      if (step_tick !== (p == 0 || p == 2000 || p == 4000 || p == 6000)) bad_tick++;
      if (step_idx !== exp_idx) bad_idx++;
      if (done !== 1'b0) n_done++;
      if (busy !== 1'b1) bad_busy++;
    end
    n_checks++; if (n_ticks !== 8) begin n_fail++; $display("FAIL loop_tick_count: got %0d expected 8", n_ticks); end
    n_checks++; if (bad_tick !== 0) begin n_fail++; $display("FAIL loop_tick_spacing: got %0d bad cycles expected 0", bad_tick); end
    n_checks++; if (bad_idx !== 0) begin n_fail++; $display("FAIL loop_step_idx: got %0d bad cycles expected 0", bad_idx); end
    n_checks++; if (n_done !== 0) begin n_fail++; $display("FAIL loop_no_done: got %0d done cycles expected 0", n_done); end
    n_checks++; if (bad_busy !== 0) begin n_fail++; $display("FAIL loop_busy: got %0d bad cycles expected 0", bad_busy); end
    halt();
    loop_en = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL loop_stop_busy: got %b expected 0", busy); end
  endtask

  task automatic test_abort();
    int bad;
    bad = 0;
    do_reset();
    wr(1'b0, 3'd0, 6'b01_1001);
    wr(1'b0, 3'd1, 6'b00_0000);
    go();
    for (int i = 1; i <= 2999; i++) cyc();
    n_checks++; if (speaker !== 2'b01) begin n_fail++; $display("FAIL abort_pre_speaker: got %b expected 01", speaker); end
    halt();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b expected 0", busy); end
    n_checks++; if (speaker !== 2'b00) begin n_fail++; $display("FAIL abort_speaker: got %b expected 00", speaker); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL abort_done: got %b expected 0", done); end
    for (int i = 0; i < 50; i++) begin
      cyc();
      if ({speaker, busy, done} !== 4'd0) bad++;
    end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL abort_quiet: got %0d active cycles expected 0", bad); end
    go();
    n_checks++; if ({busy, step_tick, step_idx} !== 5'b11_000) begin n_fail++; $display("FAIL replay_start: got %b expected 11000", {busy, step_tick, step_idx}); end
    for (int i = 1; i <= 9; i++) cyc();
    n_checks++; if (speaker !== 2'b01) begin n_fail++; $display("FAIL replay_toggle: got %b expected 01", speaker); end
    for (int i = 10; i <= 2000; i++) cyc();
    n_checks++; if ({step_tick, step_idx} !== 4'b1_001) begin n_fail++; $display("FAIL replay_step1: got %b expected 1001", {step_tick, step_idx}); end
    halt();
  endtask

  task automatic test_two_voices();
    int bad;
    logic [1:0] exp, s14, s15;
    bad = 0; s14 = '0; s15 = '0;
    do_reset();
    wr(1'b0, 3'd0, 6'b01_0000);
    wr(1'b1, 3'd0, 6'b01_1100);
    go();
    for (int i = 1; i <= 1999; i++) begin
      cyc();
      exp = {1'((i / 7) % 2), 1'((i / 15) % 2)};
      if (i == 14) s14 = speaker;
      if (i == 15) s15 = speaker;
      if (speaker !== exp) bad++;
    end
    n_checks++; if (s14 !== 2'b00) begin n_fail++; $display("FAIL voices_c14: got %b expected 00", s14); end
    n_checks++; if (s15 !== 2'b01) begin n_fail++; $display("FAIL voices_c15: got %b expected 01", s15); end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL voices_waveform: got %0d bad cycles expected 0", bad); end
    halt();
  endtask

  task automatic test_reset_mid_play();
    int bad_spk, bad_busy, bad_done;
    bad_spk = 0; bad_busy = 0; bad_done = 0;
    do_reset();
    wr(1'b0, 3'd0, 6'b01_1001);
    wr(1'b0, 3'd1, 6'b00_0000);
    go();
    for (int i = 1; i <= 2499; i++) cyc();
    n_checks++; if ({busy, step_idx} !== 4'b1_001) begin n_fail++; $display("FAIL midplay_pre: got %b expected 1001", {busy, step_idx}); end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    n_checks++; if ({speaker, busy, step_idx, step_tick, done} !== 8'd0) begin n_fail++; $display("FAIL midplay_reset: got %b expected 00000000", {speaker, busy, step_idx, step_tick, done}); end
    go();
    for (int i = 1; i <= 16001; i++) begin
      cyc();
      if (speaker !== 2'b00) bad_spk++;
      if (busy !== (i < 16000)) bad_busy++;
      if (done !== (i == 16000)) bad_done++;
    end
    n_checks++; if (bad_spk !== 0) begin n_fail++; $display("FAIL silent_speaker: got %0d active cycles expected 0", bad_spk); end
    n_checks++; if (bad_busy !== 0) begin n_fail++; $display("FAIL silent_busy: got %0d bad cycles expected 0", bad_busy); end
    n_checks++; if (bad_done !== 0) begin n_fail++; $display("FAIL silent_done: got %0d bad cycles expected 0", bad_done); end
  endtask

  initial begin
    test_reset();
    test_start_stop_idle();
    test_note_sustain_finish();
    test_loop_end();
    test_abort();
    test_two_voices();
    test_reset_mid_play();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
